mem_sequencer: RTL and testbench
================================

Name: mem_sequencer

Overview:
- Multi-cycle controller that sits directly upstream of the memory-access stage.
- Accepts one execute-stage transaction at a time (LD/LDR, LDI, ST/STR, STI, or non-memory writeback) and drives the stage's mem_state, M_Control, M_Addr and M_Data cycle by cycle.
- Resolves indirect addressing internally by capturing the pointer word, then reissuing it as a direct address.
- Captures memout and presents a one-cycle writeback beat to the register file.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- RW, 3, destination-register index width.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute stage presents a transaction.
- ex_ready  out  1  sequencer can accept a transaction this cycle.
- ex_op  in  3  0=NONE, 1=LD (LD/LDR), 2=LDI, 3=ST (ST/STR), 4=STI; 5-7 reserved.
- ex_addr  in  AW  effective address from execute.
- ex_data  in  DW  store data (ST/STI) or ALU result (NONE).
- ex_dr  in  RW  destination register.
- ex_wb  in  1  NONE op writes ex_data to ex_dr.
- memout  in  DW  read data returned by the memory-access stage, valid in the same cycle.
- mem_state  out  2  0=READ_MEM, 1=READ_MEM_INDIR, 2=WRITE_MEM, 3=INIT_STATE.
- M_Control  out  1  indirect-select to the memory-access stage; always driven 0.
- M_Addr  out  AW  address to the memory-access stage.
- M_Data  out  DW  store data to the memory-access stage.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_data  out  DW  writeback value.
- wb_dr  out  RW  writeback destination register.

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high.
- Reset values:
  - state=IDLE, mem_state=3.
  - M_Addr=0, M_Data=0, M_Control=0.
  - wb_valid=0, wb_data=0, wb_dr=0.
  - Internal addr_q, data_q, dr_q, ptr_q = 0.
- Reset mid-operation: aborts the transaction. No write or writeback beat is issued after the reset edge.
- ex_ready = (state==IDLE) && !reset, combinational.
- Accept: when ex_valid && ex_ready, latch op, addr, data and dr into *_q.
- Moore outputs decoded from registered state:
  - IDLE: mem_state=3, M_Addr=0, M_Data=0.
  - RD: mem_state=0, M_Addr=addr_q.
  - IND1: mem_state=1, M_Addr=addr_q.
  - IND2: mem_state=0, M_Addr=ptr_q.
  - WR: mem_state=2, M_Addr=addr_q, M_Data=data_q.
  - WRI: mem_state=2, M_Addr=ptr_q, M_Data=data_q.
  - M_Data=0 in every state except WR and WRI.
- Transitions from IDLE on accept:
  - op1 -> RD
  - op2 -> IND1
  - op3 -> WR
  - op4 -> IND1
  - op0 and op5-7 -> stay IDLE
- Transitions after IDLE:
  - RD -> IDLE
  - IND1 -> IND2 (op2) or WRI (op4)
  - IND2 -> IDLE
  - WR -> IDLE
  - WRI -> IDLE
- Capture points:
  - End of IND1: ptr_q <= memout.
  - End of RD or IND2: wb_data <= memout, wb_dr <= dr_q, wb_valid <= 1 for the next cycle only.
- NONE op: accepted with ex_wb=1 -> next cycle wb_valid=1, wb_data=ex_data, wb_dr=ex_dr. With ex_wb=0, no pulse.
- Reserved ops: accepted, no memory activity, no writeback.
- wb_valid is 0 in all other cycles. wb_data and wb_dr hold their last value.
- Latency and occupancy, accept cycle to wb_valid:
  - NONE: 1 cycle; back-to-back accepts allowed.
  - LD: 2 cycles; busy 1 cycle after accept.
  - LDI: 3 cycles; busy 2 cycles.
  - ST: busy 1 cycle.
  - STI: busy 2 cycles.
- Simultaneous events:
  - A new accept in the IDLE cycle that carries a previous load's wb_valid pulse is legal.
  - The pulse is unaffected, and the new op's pulse follows per its latency.
  - ex_valid while busy is ignored; upstream must hold it.
- Arithmetic: no address arithmetic; addresses pass through unmodified at full 16-bit width.

Test Plan:
- Reset mid-LDI: reset asserted during IND1 -> next cycle state IDLE, mem_state=3, wb_valid stays 0, ex_ready=1 after reset falls.
- LD: ex_op=1, addr=0x3000, dr=2, memout=0xBEEF in RD -> cycle+1 mem_state=0, M_Addr=0x3000; cycle+2 wb_valid=1, wb_data=0xBEEF, wb_dr=2.
- LDI: ex_op=2, addr=0x3010, memout=0x4000 in IND1 then 0x1234 in IND2 -> mem_state sequence 1,0; M_Addr sequence 0x3010,0x4000; wb_data=0x1234 at cycle+3.
- STI: ex_op=4, addr=0x3020, data=0x5A5A, memout=0x4100 in IND1 -> WRI with mem_state=2, M_Addr=0x4100, M_Data=0x5A5A; no wb_valid.
- Back-to-back NONE: three accepts with ex_wb=1, data 1/2/3 -> wb_valid high three consecutive cycles with 1,2,3; ex_ready never drops.
- Busy hold: ST accepted, then ex_valid held with op=1 -> ex_ready=0 in WR, LD accepted the following IDLE cycle; reserved op 6 -> no mem_state change, no writeback.

Source files
------------

// File: rtl/mem_sequencer.sv
// mem_sequencer: multi-cycle controller feeding the memory-access stage.
// Accepts one execute-stage transaction at a time and sequences it as
// direct load, indirect load, direct store, indirect store or a
// non-memory writeback. The memory-access stage is driven cycle by cycle.
// Indirect addressing is resolved here: the pointer word is captured and
// then reissued as a direct address, so M_Control is always 0.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   ex_valid/ex_ready     transaction handshake from execute
//   ex_op, ex_addr,       0=NONE 1=LD 2=LDI 3=ST 4=STI (5-7 reserved),
//   ex_data, ex_dr, ex_wb effective address, store data or ALU result,
//                         destination register, NONE-writeback enable
//   memout                read data from the memory stage (same cycle)
//   mem_state             0=READ 1=READ_INDIR 2=WRITE 3=INIT
//   M_Control, M_Addr,    memory-stage control, address and store data
//   M_Data
//   wb_valid, wb_data,    one-cycle writeback beat to the register file
//   wb_dr
module mem_sequencer #(
   parameter int AW = 16,
   parameter int DW = 16,
   parameter int RW = 3
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          ex_valid,
   output logic          ex_ready,
   input  logic [2:0]    ex_op,
   input  logic [AW-1:0] ex_addr,
   input  logic [DW-1:0] ex_data,
   input  logic [RW-1:0] ex_dr,
   input  logic          ex_wb,
   input  logic [DW-1:0] memout,
   output logic [1:0]    mem_state,
   output logic          M_Control,
   output logic [AW-1:0] M_Addr,
   output logic [DW-1:0] M_Data,
   output logic          wb_valid,
   output logic [DW-1:0] wb_data,
   output logic [RW-1:0] wb_dr
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_IND1, S_IND2, S_WR, S_WRI
   } state_t;

   localparam logic [2:0] OP_NONE = 3'd0;
   localparam logic [2:0] OP_LD   = 3'd1;
   localparam logic [2:0] OP_LDI  = 3'd2;
   localparam logic [2:0] OP_ST   = 3'd3;
   localparam logic [2:0] OP_STI  = 3'd4;

   state_t        state_q, state_d;
   logic [2:0]    op_q, op_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic [RW-1:0] dr_q, dr_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          wb_valid_q, wb_valid_d;
   logic [DW-1:0] wb_data_q, wb_data_d;
   logic [RW-1:0] wb_dr_q, wb_dr_d;

   logic accept;

   assign ex_ready  = (state_q == S_IDLE) && !reset;
   assign accept    = ex_valid && ex_ready;
   assign M_Control = 1'b0;
   assign wb_valid  = wb_valid_q;
   assign wb_data   = wb_data_q;
   assign wb_dr     = wb_dr_q;

   // Next state and capture logic
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      data_d     = data_q;
      dr_d       = dr_q;
      ptr_d      = ptr_q;
      wb_valid_d = 1'b0;
      wb_data_d  = wb_data_q;
      wb_dr_d    = wb_dr_q;
      case (state_q)
         S_IDLE: if (accept) begin
            op_d   = ex_op;
            addr_d = ex_addr;
            data_d = ex_data;
            dr_d   = ex_dr;
            case (ex_op)
               OP_LD:  state_d = S_RD;
               OP_LDI: state_d = S_IND1;
               OP_ST:  state_d = S_WR;
               OP_STI: state_d = S_IND1;
               OP_NONE: if (ex_wb) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = ex_data;
                  wb_dr_d    = ex_dr;
               end
               default: ;  // reserved: consumed with no effect
            endcase
         end
         S_RD, S_IND2: begin
            wb_valid_d = 1'b1;
            wb_data_d  = memout;
            wb_dr_d    = dr_q;
            state_d    = S_IDLE;
         end
         S_IND1: begin
            // pointer word is a full-width address
            ptr_d   = memout[AW-1:0];
            state_d = (op_q == OP_STI) ? S_WRI : S_IND2;
         end
         S_WR, S_WRI: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Moore decode of memory-stage outputs
   always_comb begin
      mem_state = 2'd3;
      M_Addr    = '0;
      M_Data    = '0;
      case (state_q)
         S_RD:   begin mem_state = 2'd0; M_Addr = addr_q; end
         S_IND1: begin mem_state = 2'd1; M_Addr = addr_q; end
         S_IND2: begin mem_state = 2'd0; M_Addr = ptr_q;  end
         S_WR:   begin mem_state = 2'd2; M_Addr = addr_q; M_Data = data_q; end
         S_WRI:  begin mem_state = 2'd2; M_Addr = ptr_q;  M_Data = data_q; end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         dr_q       <= '0;
         ptr_q      <= '0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_dr_q    <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         dr_q       <= dr_d;
         ptr_q      <= ptr_d;
         wb_valid_q <= wb_valid_d;
         wb_data_q  <= wb_data_d;
         wb_dr_q    <= wb_dr_d;
      end
   end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: inputs change and outputs are checked
// a couple of time units after each rising clock edge.
module tb_mem_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic        ex_ready;
   logic [2:0]  ex_op;
   logic [15:0] ex_addr;
   logic [15:0] ex_data;
   logic [2:0]  ex_dr;
   logic        ex_wb;
   logic [15:0] memout;
   logic [1:0]  mem_state;
   logic        M_Control;
   logic [15:0] M_Addr;
   logic [15:0] M_Data;
   logic        wb_valid;
   logic [15:0] wb_data;
   logic [2:0]  wb_dr;

   int n_cmp = 0;
   int n_err = 0;

   mem_sequencer #(.AW(16), .DW(16), .RW(3)) dut (
      .clock(clock), .reset(reset),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
      .ex_addr(ex_addr), .ex_data(ex_data), .ex_dr(ex_dr), .ex_wb(ex_wb),
      .memout(memout), .mem_state(mem_state), .M_Control(M_Control),
      .M_Addr(M_Addr), .M_Data(M_Data),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_dr(wb_dr)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] d, input logic [2:0] r, input logic w);
      ex_valid = v; ex_op = op; ex_addr = a; ex_data = d; ex_dr = r; ex_wb = w;
      #1;
   endtask

   initial begin
      reset = 1'b1; memout = '0;
      drive(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b0);
      tick(); tick();
      // reset state
      chk("rst_ready", ex_ready, 0);
      chk("rst_mstate", mem_state, 3);
      chk("rst_maddr", M_Addr, 0);
      chk("rst_mdata", M_Data, 0);
      chk("rst_mctl", M_Control, 0);
      chk("rst_wbv", wb_valid, 0);
      chk("rst_wbd", wb_data, 0);
      chk("rst_wbdr", wb_dr, 0);
      reset = 1'b0; #1;
      chk("rst_ready_after", ex_ready, 1);

      // LD 0x3000 -> r2
      drive(1'b1, 3'd1, 16'h3000, 16'h0, 3'd2, 1'b0);
      tick();
      drive(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b0);
      memout = 16'hBEEF; #1;
      chk("ld_mstate", mem_state, 0);
      chk("ld_maddr", M_Addr, 16'h3000);
      chk("ld_busy", ex_ready, 0);
      chk("ld_wbv_early", wb_valid, 0);
      tick();
      chk("ld_wbv", wb_valid, 1);
      chk("ld_wbd", wb_data, 16'hBEEF);
      chk("ld_wbdr", wb_dr, 2);
      chk("ld_idle", mem_state, 3);
      chk("ld_ready", ex_ready, 1);
      tick();
      chk("ld_wbv_drop", wb_valid, 0);
      chk("ld_wbd_hold", wb_data, 16'hBEEF);

      // LDI 0x3010 -> ptr 0x4000 -> 0x1234 into r5
      drive(1'b1, 3'd2, 16'h3010, 16'h0, 3'd5, 1'b0);
      tick();
      drive(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b0);
      memout = 16'h4000; #1;
      chk("ldi_ms1", mem_state, 1);
      chk("ldi_ad1", M_Addr, 16'h3010);
      tick();
      memout = 16'h1234; #1;
      chk("ldi_ms2", mem_state, 0);
      chk("ldi_ad2", M_Addr, 16'h4000);
      chk("ldi_wbv_early", wb_valid, 0);
      tick();
      chk("ldi_wbv", wb_valid, 1);
      chk("ldi_wbd", wb_data, 16'h1234);
      chk("ldi_wbdr", wb_dr, 5);

      // STI 0x3020 -> ptr 0x4100, data 0x5A5A
      drive(1'b1, 3'd4, 16'h3020, 16'h5A5A, 3'd1, 1'b0);
      tick();
      drive(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b0);
      memout = 16'h4100; #1;
      chk("sti_ms1", mem_state, 1);
      chk("sti_md1", M_Data, 0);
      tick();
      memout = 16'hDEAD; #1;
      chk("sti_ms2", mem_state, 2);
      chk("sti_ad2", M_Addr, 16'h4100);
      chk("sti_md2", M_Data, 16'h5A5A);
      chk("sti_wbv", wb_valid, 0);
      tick();
      chk("sti_idle", mem_state, 3);
      chk("sti_wbv2", wb_valid, 0);
      chk("sti_wbd_hold", wb_data, 16'h1234);

      // back-to-back NONE writebacks
      drive(1'b1, 3'd0, 16'h0, 16'h1, 3'd1, 1'b1);
      tick();
      chk("n1_wbv", wb_valid, 1);
      chk("n1_wbd", wb_data, 1);
      chk("n1_wbdr", wb_dr, 1);
      drive(1'b1, 3'd0, 16'h0, 16'h2, 3'd3, 1'b1);
      chk("n1_ready", ex_ready, 1);
      tick();
      chk("n2_wbv", wb_valid, 1);
      chk("n2_wbd", wb_data, 2);
      chk("n2_wbdr", wb_dr, 3);
      drive(1'b1, 3'd0, 16'h0, 16'h3, 3'd6, 1'b1);
      chk("n2_ready", ex_ready, 1);
      tick();
      chk("n3_wbv", wb_valid, 1);
      chk("n3_wbd", wb_data, 3);
      chk("n3_wbdr", wb_dr, 6);
      // NONE without writeback
      drive(1'b1, 3'd0, 16'h0, 16'h9, 3'd7, 1'b0);
      tick();
      chk("nwb0_wbv", wb_valid, 0);
      chk("nwb0_wbd", wb_data, 3);
      chk("nwb0_ms", mem_state, 3);

      // ST then held LD: ignored while busy, accepted in following IDLE
      drive(1'b1, 3'd3, 16'h5000, 16'hABCD, 3'd0, 1'b0);
      tick();
      drive(1'b1, 3'd1, 16'h6000, 16'h0, 3'd4, 1'b0);
      chk("st_busy", ex_ready, 0);
      chk("st_ms", mem_state, 2);
      chk("st_ad", M_Addr, 16'h5000);
      chk("st_md", M_Data, 16'hABCD);
      tick();
      chk("hold_ready", ex_ready, 1);
      chk("hold_ms", mem_state, 3);
      chk("hold_md", M_Data, 0);
      tick();
      drive(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b0);
      memout = 16'h7777; #1;
      chk("hold_ld_ms", mem_state, 0);
      chk("hold_ld_ad", M_Addr, 16'h6000);
      tick();
      // accept reserved op 6 in the cycle carrying the LD pulse
      drive(1'b1, 3'd6, 16'h7000, 16'h1111, 3'd2, 1'b1);
      chk("hold_wbv", wb_valid, 1);
      chk("hold_wbd", wb_data, 16'h7777);
      chk("hold_wbdr", wb_dr, 4);
      tick();
      drive(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b0);
      chk("rsv_ms", mem_state, 3);
      chk("rsv_wbv", wb_valid, 0);
      chk("rsv_ready", ex_ready, 1);
      chk("rsv_wbd", wb_data, 16'h7777);

      // reset during IND1 of an LDI
      drive(1'b1, 3'd2, 16'h3030, 16'h0, 3'd3, 1'b0);
      tick();
      drive(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b0);
      memout = 16'h4444; #1;
      chk("rmid_ms1", mem_state, 1);
      reset = 1'b1;
      tick();
      chk("rmid_ms", mem_state, 3);
      chk("rmid_wbv", wb_valid, 0);
      chk("rmid_ad", M_Addr, 0);
      reset = 1'b0; #1;
      chk("rmid_ready", ex_ready, 1);
      tick();
      chk("rmid_wbv2", wb_valid, 0);
      chk("rmid_ms2", mem_state, 3);
      chk("rmid_wbd", wb_data, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // global time bound
   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
